// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_rst.
// Lock loss or lock timeout re-pulses the PLL and bumps a saturating attempt counter.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count
);

    localparam int unsigned MaxAB     = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                        RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MaxCycles = (MaxAB > LOCK_TIMEOUT_CYCLES) ? MaxAB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0]  RstLast     = CntW'(RST_PULSE_CYCLES - 1);
    localparam logic [CntW-1:0]  StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0]  TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RelockMax   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StPllReset,
        StWaitLock,
        StStabilize,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        sync_q;
    logic              locked_s;
    logic              relock_inc;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_rst_q, sys_rst_d;
    logic              ready_q, ready_d;
    logic              lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]  relock_q, relock_d;

    assign locked_s = sync_q[1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= StPllReset;
            cnt_q       <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            relock_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], pll_locked};
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            relock_q    <= relock_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        relock_inc = 1'b0;
        unique case (state_q)
            StPllReset: begin
                if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStabilize;
                end else if (cnt_q == TimeoutLast) begin
                    state_d    = StPllReset;
                    relock_inc = 1'b1;
                end
            end
            StStabilize: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!locked_s) begin
                    state_d    = StPllReset;
                    relock_inc = 1'b1;
                end
            end
            default: state_d = StPllReset;
        endcase
        // Counter is held at zero in RUN so it never wraps there.
        if (state_d != state_q || state_q == StRun) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pll_rst_d   = (state_d == StPllReset);
        sys_rst_d   = (state_d != StRun);
        ready_d     = (state_d == StRun);
        lock_lost_d = (state_q == StRun) && !locked_s;
        relock_d    = relock_q;
        if (relock_inc && relock_q != RelockMax) begin
            relock_d = relock_q + 1'b1;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus pushes timed expected output vectors,
// a negedge monitor pops and compares them against {pll_rst, sys_rst, ready, lock_lost, count}.
module tb_pll_reset_sequencer;

    localparam int unsigned P = 4;
    localparam int unsigned S = 8;
    localparam int unsigned T = 32;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] relock_count;
    logic [7:0] obs;

    typedef struct {
        int         cyc;
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_STABLE_CYCLES  (S),
        .LOCK_TIMEOUT_CYCLES (T),
        .CNT_W               (4)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .relock_count (relock_count)
    );

    assign obs = {pll_rst, sys_rst, ready, lock_lost, relock_count};

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, want);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [7:0] v);
        sb.push_back('{cyc: c, tag: tag, val: v});
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    function automatic logic [3:0] sat(input int k);
        return (k > 15) ? 4'd15 : 4'(k);
    endfunction

    always @(negedge refclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, obs, sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        int r, l, a, g, m, t, r2;
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Bring-up: reset values, 4-cycle pll_rst, sys_rst falls 2+8 edges after lock.
        r = 3;
        l = r + 10;
        expect_at(1,      "reset_state", 8'hC0);
        expect_at(r,      "reset_held",  8'hC0);
        expect_at(r + 3,  "pulse_end",   8'hC0);
        expect_at(r + 4,  "pulse_off",   8'h40);
        expect_at(l + 10, "stab_last",   8'h40);
        expect_at(l + 11, "run_entry",   8'h20);
        goto(r);
        rst = 1'b0;
        goto(l);
        pll_locked = 1'b1;

        // Lock loss in RUN, then a one-cycle glitch during the relock's stabilize window.
        a = l + 14;
        g = a + 7;
        expect_at(a + 2,  "run_before_loss", 8'h20);
        expect_at(a + 3,  "lock_lost_pulse", 8'hD1);
        expect_at(a + 4,  "lock_lost_clear", 8'hC1);
        expect_at(a + 6,  "loss_pulse_end",  8'hC1);
        expect_at(a + 7,  "loss_wait_lock",  8'h41);
        expect_at(g + 8,  "glitch_back",     8'h41);
        expect_at(g + 16, "glitch_stab_end", 8'h41);
        expect_at(g + 17, "glitch_run",      8'h21);
        goto(a);
        pll_locked = 1'b0;
        goto(g);
        pll_locked = 1'b1;
        goto(g + 5);
        pll_locked = 1'b0;
        goto(g + 6);
        pll_locked = 1'b1;

        // Reset mid-RUN with lock held: count clears, full pulse, lock during pulse ignored.
        m = g + 20;
        expect_at(m,      "run_pre_rst",    8'h21);
        expect_at(m + 1,  "mid_rst",        8'hC0);
        expect_at(m + 2,  "locked_ignored", 8'hC0);
        expect_at(m + 4,  "rst_pulse_end",  8'hC0);
        expect_at(m + 5,  "rst_pulse_off",  8'h40);
        expect_at(m + 13, "rst_stab_last",  8'h40);
        expect_at(m + 14, "rst_run",        8'h20);
        goto(m);
        rst = 1'b1;
        goto(m + 1);
        rst = 1'b0;

        // Timeout with lock held low: period P+T, count saturates at 15.
        t  = m + 20;
        r2 = t + 1;
        expect_at(r2, "to_reset", 8'hC0);
        for (int k = 1; k <= 17; k++) begin
            expect_at(r2 + 36 * k - 1, "to_wait_last", {4'h4, sat(k - 1)});
            expect_at(r2 + 36 * k,     "to_repulse",   {4'hC, sat(k)});
            expect_at(r2 + 36 * k + 3, "to_pulse_end", {4'hC, sat(k)});
            expect_at(r2 + 36 * k + 4, "to_pulse_off", {4'h4, sat(k)});
        end
        goto(t);
        rst        = 1'b1;
        pll_locked = 1'b0;
        goto(t + 1);
        rst = 1'b0;

        goto(r2 + 36 * 17 + 8);
        check("sb_drain", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: refclk cycles for which pll_rst is held high per reset attempt (min 2).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before releasing sys_rst (min 2).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles waited for lock before re-pulsing pll_rst (min 2).
REQ-004 SHALL have parameter CNT_W, default 8: width of relock_count.
REQ-005 refclk  in  1  sole clock, 50.0 MHz board reference; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL locked indication, asynchronous to refclk.
REQ-008 pll_rst  out  1  reset to PLL, registered.
REQ-009 sys_rst  out  1  reset to logic clocked by the PLL output, registered, active-high.
REQ-010 ready  out  1  high only in RUN, registered.
REQ-011 lock_lost  out  1  one-cycle pulse on loss of lock in RUN.
REQ-012 relock_count  out  CNT_W  count of PLL re-reset attempts (timeouts plus lock losses), saturating.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; locked_s is pll_locked delayed 2 refclk cycles; the FSM SHALL use only locked_s.
REQ-014 FSM states SHALL be PLL_RESET, WAIT_LOCK, STABILIZE, RUN, with one shared cycle counter cleared on every state change.
REQ-015 PLL_RESET: pll_rst=1; after RST_PULSE_CYCLES cycles in the state -> WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABILIZE; otherwise, on the LOCK_TIMEOUT_CYCLES-th cycle in the state -> PLL_RESET and relock_count increments.
REQ-017 STABILIZE: locked_s=0 -> WAIT_LOCK, no increment, timeout restarts; locked_s=1 on the LOCK_STABLE_CYCLES-th consecutive cycle -> RUN.
REQ-018 RUN: sys_rst=0, ready=1; locked_s=0 -> PLL_RESET, lock_lost=1 for exactly that one cycle, relock_count increments.
REQ-019 sys_rst SHALL be 1 and ready 0 in every state other than RUN; pll_rst SHALL be 1 only in PLL_RESET.
REQ-020 Outputs SHALL be registered from next-state, i.e. change on the same edge the state changes.
REQ-021 relock_count SHALL saturate at 2^CNT_W-1 and never wrap; it clears only on rst.
REQ-022 Glitches on locked_s shorter than LOCK_STABLE_CYCLES in STABILIZE SHALL NOT release sys_rst.
REQ-023 A locked_s=1 while in PLL_RESET SHALL be ignored; the pulse always completes full length.

Reset
REQ-024 While rst=1 at a refclk edge: state=PLL_RESET, counter=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, relock_count=0.
REQ-025 rst asserted mid-operation (any state, including RUN) SHALL take effect on the next edge with REQ-024 values; the sequence restarts with a full pll_rst pulse on release.
REQ-026 Reset SHALL not be counted as a relock attempt.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, CNT_W=4)
REQ-027 Normal bring-up: release rst, raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles; sys_rst falls 2+8 cycles after pll_locked rises (±1 per REQ-020 reference edge); ready=1, relock_count=0.
REQ-028 Timeout: pll_locked held 0 -> pll_rst re-pulses for 4 cycles every 36 cycles; relock_count counts 1,2,3..., saturates at 15 and stays 15.
REQ-029 Lock glitch: in STABILIZE drop pll_locked for 1 cycle after 5 locked cycles -> returns to WAIT_LOCK, sys_rst stays 1, relock_count unchanged; sys_rst falls only after 8 further consecutive locked cycles.
REQ-030 Loss in RUN: drop pll_locked -> 2 cycles later lock_lost high exactly 1 cycle, sys_rst=1, ready=0, pll_rst=1 for 4 cycles, relock_count +1.
REQ-031 Reset mid-RUN: assert rst 1 cycle with pll_locked=1 -> next edge all outputs at REQ-024 values; full 4-cycle pll_rst pulse then normal bring-up.
REQ-032 Lock during PLL_RESET: pll_locked=1 throughout -> pll_rst still high 4 full cycles, then STABILIZE, sys_rst released after 8 locked cycles.
